// File: rtl/fma16_pkg.sv
// Shared types and constants for the fma16 round/pack stage.
package fma16_pkg;

  typedef enum logic [1:0] {
    RZ  = 2'b00,
    RNE = 2'b01,
    RM  = 2'b10,
    RP  = 2'b11
  } rnd_mode_t;

  typedef enum logic [1:0] {
    SP_NORMAL  = 2'b00,
    SP_ZERO    = 2'b01,
    SP_INF     = 2'b10,
    SP_INVALID = 2'b11
  } special_t;

  // Bit positions inside the {NV,OF,UF,NX} flag vector
  localparam int NV_IDX = 3;
  localparam int OF_IDX = 2;
  localparam int UF_IDX = 1;
  localparam int NX_IDX = 0;

  localparam logic [15:0] QNAN16 = 16'h7E00;
  localparam logic [15:0] INF16  = 16'h7C00;
  localparam logic [15:0] MAXF16 = 16'h7BFF;

  // On overflow, decide whether the rounding direction lands on infinity
  // (otherwise the result saturates to the largest finite magnitude).
  function automatic logic overflow_to_inf(input rnd_mode_t mode, input logic sign);
    logic r;
    r = 1'b0;
    case (mode)
      RNE:     r = 1'b1;
      RP:      r = !sign;
      RM:      r = sign;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fma16_round_incr.sv
// Rounding-increment decision for one binary16 result.
// Pure combinational: given the fraction LSB, guard and sticky bits, the sign
// and the rounding mode, produce the +1 ulp increment and the inexact indication.
module fma16_round_incr
  import fma16_pkg::*;
(
  input  logic      frac_lsb,
  input  logic      g,
  input  logic      t,
  input  logic      sign,
  input  rnd_mode_t mode,
  output logic      inc,
  output logic      inexact
);

  // Increment selection per rounding direction
  always_comb begin
    inc = 1'b0;
    case (mode)
      RZ:      inc = 1'b0;
      RNE:     inc = g & (t | frac_lsb);
      RM:      inc = sign & (g | t);
      RP:      inc = !sign & (g | t);
      default: inc = 1'b0;
    endcase
  end

  assign inexact = g | t;

endmodule

// File: rtl/fma16_round_pack.sv
// fma16_round_pack: rounds the aligned significand from the multiply/align
// stage and packs an IEEE binary16 result with {NV,OF,UF,NX} flags.
// Two-stage valid/ready pipeline: S1 captures and extracts guard/sticky,
// S2 rounds, handles overflow/specials and holds the packed result.
// Optional feature: define FMA16_STICKY_FLAGS_EN to get the accumulated
// sticky flag register (flags_acc / flag_clr); otherwise flags_acc is 0.
module fma16_round_pack
  import fma16_pkg::*;
#(
  parameter int VEC_SIZE = 47,
  parameter int END_BITS = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [VEC_SIZE:0]   mm,
  input  logic [4:0]          me,
  input  logic                ms,
  input  logic [1:0]          special,
  input  logic [1:0]          roundmode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [15:0]         result,
  output logic [3:0]          flags,
  input  logic                flag_clr,
  output logic [3:0]          flags_acc
);

  // ---------------- handshake ----------------
  logic s1_valid_reg;
  logic s2_valid_reg;
  logic s1_adv;
  logic s2_adv;
  logic out_xfer;

  assign s2_adv   = !s2_valid_reg | out_ready;
  assign s1_adv   = !s1_valid_reg | s2_adv;
  assign in_ready = s1_adv;
  assign out_xfer = s2_valid_reg & out_ready;

  // ---------------- stage 1 ----------------
  logic       s1_sign_reg;
  logic [4:0] s1_exp_reg;
  logic [9:0] s1_frac_reg;
  logic       s1_g_reg;
  logic       s1_t_reg;
  special_t   s1_special_reg;
  rnd_mode_t  s1_mode_reg;

  // Capture the incoming operand and reduce the tail below G into sticky T
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_reg   <= 1'b0;
      s1_sign_reg    <= 1'b0;
      s1_exp_reg     <= 5'd0;
      s1_frac_reg    <= 10'd0;
      s1_g_reg       <= 1'b0;
      s1_t_reg       <= 1'b0;
      s1_special_reg <= SP_NORMAL;
      s1_mode_reg    <= RZ;
    end else if (s1_adv) begin
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        s1_sign_reg    <= ms;
        s1_exp_reg     <= me;
        s1_frac_reg    <= mm[END_BITS+19:END_BITS+10];
        s1_g_reg       <= mm[END_BITS+9];
        s1_t_reg       <= |mm[END_BITS+8:0];
        s1_special_reg <= special_t'(special);
        s1_mode_reg    <= rnd_mode_t'(roundmode);
      end
    end
  end

  // Bits of mm above the fraction field carry no information for rounding
  generate
    if (VEC_SIZE > END_BITS + 19) begin : g_mm_hi
      logic unused_mm_hi;
      assign unused_mm_hi = |mm[VEC_SIZE:END_BITS+20];
    end
  endgenerate

  // ---------------- stage 2: round / pack ----------------
  logic        inc;
  logic        inexact;
  logic [14:0] sum_next;
  logic        ovf;
  logic [15:0] result_next;
  logic [3:0]  flags_next;

  fma16_round_incr u_round_incr (
    .frac_lsb (s1_frac_reg[0]),
    .g        (s1_g_reg),
    .t        (s1_t_reg),
    .sign     (s1_sign_reg),
    .mode     (s1_mode_reg),
    .inc      (inc),
    .inexact  (inexact)
  );

  // Exponent and fraction are added as one field so a fraction carry
  // bumps the exponent naturally (including 0x1E -> 0x1F overflow).
  assign sum_next = {s1_exp_reg, s1_frac_reg} + {14'd0, inc};
  assign ovf      = (sum_next[14:10] == 5'h1F) | (s1_exp_reg == 5'h1F);

  // Select the packed result and flags for the operand class
  always_comb begin
    result_next = {s1_sign_reg, sum_next};
    flags_next  = 4'b0000;
    case (s1_special_reg)
      SP_ZERO: begin
        result_next = {s1_sign_reg, 15'd0};
      end
      SP_INF: begin
        result_next = {s1_sign_reg, 5'h1F, 10'd0};
      end
      SP_INVALID: begin
        result_next        = QNAN16;
        flags_next[NV_IDX] = 1'b1;
      end
      default: begin
        if (ovf) begin
          result_next        = (overflow_to_inf(s1_mode_reg, s1_sign_reg) ? INF16 : MAXF16)
                               | {s1_sign_reg, 15'd0};
          flags_next[OF_IDX] = 1'b1;
          flags_next[NX_IDX] = 1'b1;
        end else begin
          result_next        = {s1_sign_reg, sum_next};
          flags_next[NX_IDX] = inexact;
          flags_next[UF_IDX] = (s1_exp_reg == 5'd0) & inexact;
        end
      end
    endcase
  end

  logic [15:0] result_reg;
  logic [3:0]  flags_reg;

  // Output register; holds its value while the consumer stalls
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid_reg <= 1'b0;
      result_reg   <= 16'h0000;
      flags_reg    <= 4'b0000;
    end else if (s2_adv) begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        result_reg <= result_next;
        flags_reg  <= flags_next;
      end
    end
  end

  assign out_valid = s2_valid_reg;
  assign result    = result_reg;
  assign flags     = flags_reg;

  // ---------------- sticky flags ----------------
`ifdef FMA16_STICKY_FLAGS_EN
  logic [3:0] flags_acc_reg;

  // Accumulate flags of delivered results; a clear keeps only a coincident transfer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags_acc_reg <= 4'b0000;
    end else if (flag_clr) begin
      flags_acc_reg <= out_xfer ? flags_reg : 4'b0000;
    end else if (out_xfer) begin
      flags_acc_reg <= flags_acc_reg | flags_reg;
    end
  end

  assign flags_acc = flags_acc_reg;
`else
  logic unused_sticky;
  assign unused_sticky = flag_clr | out_xfer;
  assign flags_acc     = 4'b0000;
`endif

endmodule

// File: tb/tb_fma16_round_pack.sv
// Directed self-checking bench for fma16_round_pack.
// Sticky-flag checks are compiled in when FMA16_STICKY_FLAGS_EN is defined.
`timescale 1ns/1ps
module tb_fma16_round_pack;

  localparam int VS = 47;
  localparam int EB = 8;

  logic          clk;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [VS:0]   mm;
  logic [4:0]    me;
  logic          ms;
  logic [1:0]    special;
  logic [1:0]    roundmode;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   result;
  logic [3:0]    flags;
  logic          flag_clr;
  logic [3:0]    flags_acc;

  int errors = 0;
  int checks = 0;

  fma16_round_pack #(.VEC_SIZE(VS), .END_BITS(EB)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mm        (mm),
    .me        (me),
    .ms        (ms),
    .special   (special),
    .roundmode (roundmode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags),
    .flag_clr  (flag_clr),
    .flags_acc (flags_acc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Drive one operand onto the input bus (fraction, guard, sticky placed in mm)
  task automatic set_inputs(input logic [4:0] e, input logic [9:0] fr, input logic g,
                            input logic t, input logic s, input logic [1:0] sp,
                            input logic [1:0] rm);
    logic [VS:0] v;
    v = '0;
    v[EB+19 -: 10] = fr;
    v[EB+9]        = g;
    v[0]           = t;     // lowest tail bit must still reach sticky
    v[VS]          = 1'b1;  // junk above the field must be ignored
    mm        = v;
    me        = e;
    ms        = s;
    special   = sp;
    roundmode = rm;
  endtask

  // One transaction with out_ready=1: checks latency, result and (optionally) flags
  task automatic run_vec(input string tag, input logic [4:0] e, input logic [9:0] fr,
                         input logic g, input logic t, input logic s, input logic [1:0] sp,
                         input logic [1:0] rm, input logic [15:0] exp_res,
                         input logic [3:0] exp_fl, input logic chk_fl);
    int n;
    @(negedge clk);
    out_ready = 1'b1;
    set_inputs(e, fr, g, t, s, sp, rm);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, n, 1);
    check({tag, " result"}, {16'd0, result}, {16'd0, exp_res});
    if (chk_fl) check({tag, " flags"}, {28'd0, flags}, {28'd0, exp_fl});
    $display("txn %-12s result=%h flags=%b", tag, result, flags);
  endtask

  initial begin
    logic [15:0] stall_exp [4];
    logic [9:0]  stall_frac [4];
    int          tx, rx, acc_at_drop, n;
    logic        prev_stall;
    logic [15:0] prev_res;
    logic [3:0]  prev_fl;

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flag_clr  = 1'b0;
    mm        = '0;
    me        = 5'd0;
    ms        = 1'b0;
    special   = 2'b00;
    roundmode = 2'b00;

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    check("rst in_ready", {31'd0, in_ready}, 32'd1);
    check("rst out_valid", {31'd0, out_valid}, 32'd0);
    check("rst result", {16'd0, result}, 32'd0);
    check("rst flags", {28'd0, flags}, 32'd0);
    check("rst flags_acc", {28'd0, flags_acc}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

`ifdef FMA16_STICKY_FLAGS_EN
    // ---- sticky accumulation: NX then OF ----
    run_vec("acc nx", 5'd15, 10'h155, 1'b1, 1'b0, 1'b0, 2'b00, 2'b01, 16'h3D56, 4'b0001, 1'b1);
    run_vec("acc of", 5'd30, 10'h3FF, 1'b1, 1'b0, 1'b1, 2'b00, 2'b10, 16'hFC00, 4'b0101, 1'b1);
    @(negedge clk);
    check("acc nx|of", {28'd0, flags_acc}, 32'h5);
    // clear coinciding with an NV transfer
    out_ready = 1'b0;
    set_inputs(5'd0, 10'd0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b01);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("acc nv valid", {31'd0, out_valid}, 32'd1);
    flag_clr  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    flag_clr = 1'b0;
    check("acc clr+nv", {28'd0, flags_acc}, 32'h8);
    $display("txn acc-clr     flags_acc=%b", flags_acc);
    // plain clear with no transfer
    flag_clr = 1'b1;
    @(negedge clk);
    flag_clr = 1'b0;
    check("acc clr", {28'd0, flags_acc}, 32'h0);
`endif

    // ---- directed rounding vectors ----
    run_vec("rne inc", 5'd15, 10'h155, 1'b1, 1'b0, 1'b0, 2'b00, 2'b01, 16'h3D56, 4'b0001, 1'b1);
    run_vec("rz trunc", 5'd15, 10'h155, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 16'h3D55, 4'b0001, 1'b1);
    run_vec("rne tie even", 5'd15, 10'h154, 1'b1, 1'b0, 1'b0, 2'b00, 2'b01, 16'h3D54, 4'b0001, 1'b1);
    run_vec("rm neg t", 5'd15, 10'h000, 1'b0, 1'b1, 1'b1, 2'b00, 2'b10, 16'hBC01, 4'b0001, 1'b1);
    run_vec("exact", 5'd10, 10'h200, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 16'h2A00, 4'b0000, 1'b1);
    run_vec("subnorm uf", 5'd0, 10'h001, 1'b0, 1'b1, 1'b0, 2'b00, 2'b11, 16'h0002, 4'b0011, 1'b1);
    run_vec("ovf rne", 5'd30, 10'h3FF, 1'b1, 1'b0, 1'b0, 2'b00, 2'b01, 16'h7C00, 4'b0101, 1'b1);
    run_vec("ovf-edge rz", 5'd30, 10'h3FF, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 16'h7BFF, 4'b0000, 1'b0);
    run_vec("neg rp", 5'd30, 10'h3FF, 1'b1, 1'b0, 1'b1, 2'b00, 2'b11, 16'hFBFF, 4'b0000, 1'b0);
    run_vec("ovf rm neg", 5'd30, 10'h3FF, 1'b1, 1'b0, 1'b1, 2'b00, 2'b10, 16'hFC00, 4'b0101, 1'b1);
    run_vec("me1f rz", 5'h1F, 10'h000, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 16'h7BFF, 4'b0101, 1'b1);
    run_vec("nan", 5'd3, 10'h011, 1'b1, 1'b1, 1'b0, 2'b11, 2'b01, 16'h7E00, 4'b1000, 1'b1);
    run_vec("zero neg", 5'd3, 10'h011, 1'b1, 1'b1, 1'b1, 2'b01, 2'b01, 16'h8000, 4'b0000, 1'b1);
    run_vec("inf pos", 5'd3, 10'h011, 1'b1, 1'b1, 1'b0, 2'b10, 2'b11, 16'h7C00, 4'b0000, 1'b1);

`ifndef FMA16_STICKY_FLAGS_EN
    // feature disabled: flag_clr has no effect and flags_acc stays zero
    @(negedge clk);
    flag_clr = 1'b1;
    @(negedge clk);
    flag_clr = 1'b0;
    check("acc tied 0", {28'd0, flags_acc}, 32'h0);
`endif

    // ---- back-to-back with stalled consumer ----
    stall_frac[0] = 10'h011; stall_frac[1] = 10'h022;
    stall_frac[2] = 10'h033; stall_frac[3] = 10'h044;
    for (int k = 0; k < 4; k++) stall_exp[k] = {1'b0, 5'd15, stall_frac[k]};
    tx = 0; rx = 0; acc_at_drop = -1;
    prev_stall = 1'b0; prev_res = '0; prev_fl = '0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      out_ready = (c >= 5);
      if (tx < 4) begin
        set_inputs(5'd15, stall_frac[tx], 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (prev_stall)
        check($sformatf("hold c%0d", c), {11'd0, out_valid, flags, result},
              {11'd0, 1'b1, prev_fl, prev_res});
      if (out_valid && out_ready) begin
        check($sformatf("stall out%0d", rx), {12'd0, flags, result},
              {12'd0, 4'b0000, (rx < 4) ? stall_exp[rx] : 16'hDEAD});
        $display("txn stall%0d      result=%h flags=%b", rx, result, flags);
        rx++;
      end
      prev_stall = out_valid && !out_ready;
      prev_res   = result;
      prev_fl    = flags;
      if (in_valid && !in_ready && acc_at_drop < 0) acc_at_drop = tx;
      if (in_valid && in_ready) tx++;
    end
    in_valid = 1'b0;
    check("stall drop after", acc_at_drop, 2);
    check("stall count", rx, 4);

    // ---- reset while both stages hold data ----
    @(negedge clk);
    out_ready = 1'b0;
    set_inputs(5'd15, 10'h155, 1'b1, 1'b0, 1'b0, 2'b00, 2'b01);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("pre-rst full", {30'd0, out_valid, in_ready}, {30'd0, 1'b1, 1'b0});
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid-rst out_valid", {31'd0, out_valid}, 32'd0);
    check("mid-rst result", {16'd0, result}, 32'd0);
    check("mid-rst flags", {28'd0, flags}, 32'd0);
    check("mid-rst in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    n = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    check("post-rst no output", n, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
